fb_ctrl_80x60: RTL and testbench

FB_CTRL_80X60 -- requirements
Module: fb_ctrl_80x60

---
 rtl/fb_pkg.sv | 23 ++
 rtl/fb_rd_arb.sv | 60 ++++++
 rtl/fb_ctrl_80x60.sv | 114 +++++++++++
 tb/tb_fb_ctrl_80x60.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fb_pkg.sv
// Shared framebuffer geometry, widths and write-FSM types for the 80x60 RGB444 capture path.
package fb_pkg;

    localparam int unsigned FB_IMG_COLS = 80;
    localparam int unsigned FB_IMG_ROWS = 60;
    localparam int unsigned FB_IMG_PXLS = FB_IMG_COLS * FB_IMG_ROWS;
    localparam int unsigned FB_NB_ADDR  = 13;
    localparam int unsigned FB_NB_PXL   = 12;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        FULL    = 2'd2
    } wr_state_e;

    typedef struct packed {
        logic done;
        logic frm_short;
        logic ovf;
        logic skip;
    } fb_status_t;

endpackage

// File: rtl/fb_rd_arb.sv
// Fixed-priority read arbiter for the framebuffer read port: display first, processing second.
module fb_rd_arb
    import fb_pkg::*;
#(
    parameter int unsigned NB_ADDR  = FB_NB_ADDR,
    parameter int unsigned NB_PXL   = FB_NB_PXL,
    parameter int unsigned IMG_PXLS = FB_IMG_PXLS
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               disp_rd_i,
    input  logic [NB_ADDR-1:0] disp_addr_i,
    input  logic               proc_req_i,
    input  logic [NB_ADDR-1:0] proc_addr_i,
    output logic               proc_gnt_o,
    output logic [NB_ADDR-1:0] fb_addrb_o,
    input  logic [NB_PXL-1:0]  fb_doutb_i,
    output logic [NB_PXL-1:0]  disp_pxl_o,
    output logic               disp_pxl_vld_o,
    output logic [NB_PXL-1:0]  proc_pxl_o,
    output logic               proc_pxl_vld_o
);

    localparam logic [NB_ADDR-1:0] LAST_ADDR = NB_ADDR'(IMG_PXLS - 1);

    logic               disp_vld_q, disp_vld_d;
    logic               proc_vld_q, proc_vld_d;
    logic               oob_q, oob_d;
    logic [NB_ADDR-1:0] sel_addr;

    always_comb begin
        proc_gnt_o = proc_req_i & ~disp_rd_i & ~rst_i;
        disp_vld_d = disp_rd_i & ~rst_i;
        proc_vld_d = proc_gnt_o;
        sel_addr   = disp_rd_i ? disp_addr_i : proc_addr_i;
        oob_d      = sel_addr > LAST_ADDR;
        fb_addrb_o = oob_d ? '0 : sel_addr;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            disp_vld_q <= 1'b0;
            proc_vld_q <= 1'b0;
            oob_q      <= 1'b0;
        end else begin
            disp_vld_q <= disp_vld_d;
            proc_vld_q <= proc_vld_d;
            oob_q      <= oob_d;
        end
    end

    // Only one request is issued per cycle, so a single out-of-range flag covers both returns.
    always_comb begin
        disp_pxl_vld_o = disp_vld_q;
        proc_pxl_vld_o = proc_vld_q;
        disp_pxl_o     = (disp_vld_q && !oob_q) ? fb_doutb_i : '0;
        proc_pxl_o     = (proc_vld_q && !oob_q) ? fb_doutb_i : '0;
    end

endmodule

// File: rtl/fb_ctrl_80x60.sv
// Framebuffer controller: camera write FSM driving RAM port A, arbitrated reads on port B.
module fb_ctrl_80x60
    import fb_pkg::*;
#(
    parameter int unsigned C_IMG_COLS = FB_IMG_COLS,
    parameter int unsigned C_IMG_ROWS = FB_IMG_ROWS,
    parameter int unsigned C_IMG_PXLS = C_IMG_COLS * C_IMG_ROWS,
    parameter int unsigned C_NB_ADDR  = FB_NB_ADDR,
    parameter int unsigned C_NB_PXL   = FB_NB_PXL
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cam_frame_start,
    input  logic                 cam_pxl_vld,
    input  logic [C_NB_PXL-1:0]  cam_pxl,
    input  logic                 frame_lock,
    output logic                 fb_wea,
    output logic [C_NB_ADDR-1:0] fb_addra,
    output logic [C_NB_PXL-1:0]  fb_dina,
    output logic [C_NB_ADDR-1:0] fb_addrb,
    input  logic [C_NB_PXL-1:0]  fb_doutb,
    input  logic                 disp_rd,
    input  logic [C_NB_ADDR-1:0] disp_addr,
    output logic [C_NB_PXL-1:0]  disp_pxl,
    output logic                 disp_pxl_vld,
    input  logic                 proc_req,
    input  logic [C_NB_ADDR-1:0] proc_addr,
    output logic                 proc_gnt,
    output logic [C_NB_PXL-1:0]  proc_pxl,
    output logic                 proc_pxl_vld,
    output logic                 frame_done,
    output logic                 frame_short,
    output logic                 frame_ovf,
    output logic                 frame_skip
);

    localparam logic [C_NB_ADDR-1:0] LAST_ADDR = C_NB_ADDR'(C_IMG_PXLS - 1);

    wr_state_e            state_q, state_d;
    logic [C_NB_ADDR-1:0] ptr_q, ptr_d;
    fb_status_t           stat_q, stat_d;

    logic                 start_acc;
    logic                 wr_en;
    logic [C_NB_ADDR-1:0] wr_addr;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            stat_q  <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            stat_q  <= stat_d;
        end
    end

    // An accepted start always wins over the last-pixel transition and restarts at address 0.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        if (start_acc) begin
            state_d = CAPTURE;
            ptr_d   = '0;
        end
        if (wr_en) begin
            ptr_d = wr_addr + 1'b1;
            if (wr_addr == LAST_ADDR) begin
                state_d = FULL;
                ptr_d   = '0;
            end
        end
    end

    always_comb begin
        start_acc        = cam_frame_start & ~frame_lock & ~rst;
        wr_en            = cam_pxl_vld & ~rst & (start_acc | (state_q == CAPTURE));
        wr_addr          = start_acc ? '0 : ptr_q;
        fb_wea           = wr_en;
        fb_addra         = wr_en ? wr_addr : '0;
        fb_dina          = wr_en ? cam_pxl : '0;
        stat_d.done      = wr_en & (wr_addr == LAST_ADDR);
        stat_d.frm_short = start_acc & (state_q == CAPTURE);
        stat_d.ovf       = cam_pxl_vld & ~start_acc & (state_q == FULL);
        stat_d.skip      = cam_frame_start & frame_lock;
    end

    assign frame_done  = stat_q.done;
    assign frame_short = stat_q.frm_short;
    assign frame_ovf   = stat_q.ovf;
    assign frame_skip  = stat_q.skip;

    fb_rd_arb #(
        .NB_ADDR  (C_NB_ADDR),
        .NB_PXL   (C_NB_PXL),
        .IMG_PXLS (C_IMG_PXLS)
    ) u_rd_arb (
        .clk_i          (clk),
        .rst_i          (rst),
        .disp_rd_i      (disp_rd),
        .disp_addr_i    (disp_addr),
        .proc_req_i     (proc_req),
        .proc_addr_i    (proc_addr),
        .proc_gnt_o     (proc_gnt),
        .fb_addrb_o     (fb_addrb),
        .fb_doutb_i     (fb_doutb),
        .disp_pxl_o     (disp_pxl),
        .disp_pxl_vld_o (disp_pxl_vld),
        .proc_pxl_o     (proc_pxl),
        .proc_pxl_vld_o (proc_pxl_vld)
    );

endmodule

// File: tb/tb_fb_ctrl_80x60.sv
// Scoreboard bench for fb_ctrl_80x60 with a read-first, 1-cycle-latency RAM model on the ports.
module tb_fb_ctrl_80x60;

    localparam int NPX = 4800;

    typedef struct {
        int          cyc;
        logic [12:0] addr;
        logic [11:0] data;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst, cam_frame_start, cam_pxl_vld, frame_lock;
    logic [11:0] cam_pxl;
    logic        fb_wea;
    logic [12:0] fb_addra, fb_addrb;
    logic [11:0] fb_dina, fb_doutb;
    logic        disp_rd, proc_req, proc_gnt;
    logic [12:0] disp_addr, proc_addr;
    logic [11:0] disp_pxl, proc_pxl;
    logic        disp_pxl_vld, proc_pxl_vld;
    logic        frame_done, frame_short, frame_ovf, frame_skip;

    fb_ctrl_80x60 #(
        .C_IMG_COLS (80),
        .C_IMG_ROWS (60),
        .C_NB_ADDR  (13),
        .C_NB_PXL   (12)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .cam_frame_start (cam_frame_start),
        .cam_pxl_vld     (cam_pxl_vld),
        .cam_pxl         (cam_pxl),
        .frame_lock      (frame_lock),
        .fb_wea          (fb_wea),
        .fb_addra        (fb_addra),
        .fb_dina         (fb_dina),
        .fb_addrb        (fb_addrb),
        .fb_doutb        (fb_doutb),
        .disp_rd         (disp_rd),
        .disp_addr       (disp_addr),
        .disp_pxl        (disp_pxl),
        .disp_pxl_vld    (disp_pxl_vld),
        .proc_req        (proc_req),
        .proc_addr       (proc_addr),
        .proc_gnt        (proc_gnt),
        .proc_pxl        (proc_pxl),
        .proc_pxl_vld    (proc_pxl_vld),
        .frame_done      (frame_done),
        .frame_short     (frame_short),
        .frame_ovf       (frame_ovf),
        .frame_skip      (frame_skip)
    );

    always #5 clk = ~clk;

    // Read-first RAM: the registered read sees the value before this edge's write.
    logic [11:0] ram [0:8191];
    always @(posedge clk) begin
        if (fb_wea) ram[fb_addra] <= fb_dina;
        fb_doutb <= ram[fb_addrb];
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    endtask

    exp_t wr_q[$];
    exp_t rq[2][$];
    int   pq[4][$];

    function automatic string pname(input int i);
        case (i)
            0:       return "frame_done";
            1:       return "frame_short";
            2:       return "frame_ovf";
            default: return "frame_skip";
        endcase
    endfunction

    // Monitor: pops an expectation whenever its cycle arrives or the DUT presents an output.
    exp_t       mx;
    logic       e;
    logic [3:0] pul;
    logic [1:0] rv;
    logic [11:0] rd [2];
    always @(negedge clk) begin
        e = (wr_q.size() > 0) && (wr_q[0].cyc == cyc);
        if (e) begin
            mx = wr_q.pop_front();
            chk("write", {38'd0, fb_wea, fb_addra, fb_dina}, {38'd0, 1'b1, mx.addr, mx.data});
        end else if (fb_wea) begin
            chk("write_unexpected", {63'd0, fb_wea}, 64'd0);
        end

        rv = {proc_pxl_vld, disp_pxl_vld};
        rd[0] = disp_pxl;
        rd[1] = proc_pxl;
        for (int i = 0; i < 2; i++) begin
            e = (rq[i].size() > 0) && (rq[i][0].cyc == cyc);
            if (e) begin
                mx = rq[i].pop_front();
                chk(i == 0 ? "disp_read" : "proc_read", {51'd0, rv[i], rd[i]}, {51'd0, 1'b1, mx.data});
            end else if (rv[i]) begin
                chk(i == 0 ? "disp_vld_unexpected" : "proc_vld_unexpected", {63'd0, rv[i]}, 64'd0);
            end else begin
                chk(i == 0 ? "disp_pxl_zero" : "proc_pxl_zero", {52'd0, rd[i]}, 64'd0);
            end
        end

        pul = {frame_skip, frame_ovf, frame_short, frame_done};
        for (int i = 0; i < 4; i++) begin
            e = (pq[i].size() > 0) && (pq[i][0] == cyc);
            if (e || pul[i]) chk(pname(i), {63'd0, pul[i]}, {63'd0, e});
            if (e) void'(pq[i].pop_front());
        end
    end

    logic [11:0] shadow [0:8191];
    int          m_state;
    int          m_ptr;

    // Drives one cycle and pushes the behaviour the requirements predict for it.
    task automatic drive(input logic r, input logic st, input logic v, input logic [11:0] px,
                         input logic lk, input logic drd, input logic [12:0] da,
                         input logic prq, input logic [12:0] pa);
        logic        acc, wr;
        int          a;
        exp_t        x;
        rst = r; cam_frame_start = st; cam_pxl_vld = v; cam_pxl = px; frame_lock = lk;
        disp_rd = drd; disp_addr = da; proc_req = prq; proc_addr = pa;
        if (r) begin
            m_state = 0;
            m_ptr   = 0;
        end else begin
            if (drd || prq) begin
                x.cyc  = cyc + 1;
                x.addr = drd ? da : pa;
                x.data = (int'(x.addr) < NPX) ? shadow[x.addr] : 12'h000;
                if (drd) rq[0].push_back(x);
                else     rq[1].push_back(x);
            end
            acc = st && !lk;
            if (st && lk) pq[3].push_back(cyc + 1);
            if (acc && m_state == 1) pq[1].push_back(cyc + 1);
            if (v && !acc && m_state == 2) pq[2].push_back(cyc + 1);
            wr = v && (acc || m_state == 1);
            a  = acc ? 0 : m_ptr;
            if (acc) begin
                m_state = 1;
                m_ptr   = 0;
            end
            if (wr) begin
                x.cyc  = cyc;
                x.addr = 13'(a);
                x.data = px;
                wr_q.push_back(x);
                shadow[a] = px;
                m_ptr = a + 1;
                if (a == NPX - 1) begin
                    m_state = 2;
                    m_ptr   = 0;
                    pq[0].push_back(cyc + 1);
                end
            end
        end
        #1;
        chk("proc_gnt", {63'd0, proc_gnt}, {63'd0, prq && !drd && !r});
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        drive(0, 0, 0, 12'h000, 0, 0, 13'd0, 0, 13'd0);
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "_frame_done"}, {63'd0, frame_done}, 64'd0);
        chk({tag, "_frame_short"}, {63'd0, frame_short}, 64'd0);
        chk({tag, "_frame_ovf"}, {63'd0, frame_ovf}, 64'd0);
        chk({tag, "_frame_skip"}, {63'd0, frame_skip}, 64'd0);
        chk({tag, "_disp_vld"}, {63'd0, disp_pxl_vld}, 64'd0);
        chk({tag, "_proc_vld"}, {63'd0, proc_pxl_vld}, 64'd0);
        chk({tag, "_disp_pxl"}, {52'd0, disp_pxl}, 64'd0);
        chk({tag, "_proc_pxl"}, {52'd0, proc_pxl}, 64'd0);
        chk({tag, "_fb_wea"}, {63'd0, fb_wea}, 64'd0);
    endtask

    function automatic logic [11:0] pat2(input int i);
        logic [11:0] p;
        p = 12'(i);
        return p ^ 12'hA5A;
    endfunction

    function automatic logic [11:0] pat3(input int i);
        logic [11:0] p;
        p = 12'(i);
        return p ^ 12'h3C3;
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time limit reached before end of stimulus");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 8192; i++) shadow[i] = 12'h000;
        m_state = 0;
        m_ptr   = 0;
        rst = 1'b1; cam_frame_start = 1'b0; cam_pxl_vld = 1'b0; cam_pxl = '0; frame_lock = 1'b0;
        disp_rd = 1'b0; disp_addr = '0; proc_req = 1'b0; proc_addr = '0;
        @(posedge clk);
        #1;

        // Reset with traffic present: nothing may be written or returned.
        drive(1, 1, 1, 12'h123, 0, 1, 13'd5, 1, 13'd7);
        drive(1, 0, 0, 12'h000, 0, 0, 13'd0, 0, 13'd0);
        chk_quiet("reset");
        drive(0, 0, 1, 12'hABC, 0, 0, 13'd0, 0, 13'd0);

        // Full frame, pixel = addr[11:0], start coincides with the first pixel.
        for (int i = 0; i < NPX; i++) drive(0, i == 0, 1, 12'(i), 0, 0, 13'd0, 0, 13'd0);
        idle();

        // Overflow pixels while FULL, then a locked start must be skipped without writing.
        for (int i = 0; i < 3; i++) drive(0, 0, 1, 12'hEEE, 0, 0, 13'd0, 0, 13'd0);
        drive(0, 1, 1, 12'hFFF, 1, 0, 13'd0, 0, 13'd0);
        idle();

        // Arbitration and out-of-range reads.
        drive(0, 0, 0, 12'h000, 0, 1, 13'd5, 1, 13'd7);
        drive(0, 0, 0, 12'h000, 0, 0, 13'd0, 1, 13'd7);
        drive(0, 0, 0, 12'h000, 0, 0, 13'd0, 1, 13'd4800);
        drive(0, 0, 0, 12'h000, 0, 0, 13'd0, 1, 13'd8191);
        drive(0, 0, 0, 12'h000, 0, 1, 13'd4799, 0, 13'd0);
        drive(0, 0, 0, 12'h000, 0, 1, 13'd4800, 0, 13'd0);
        drive(0, 0, 0, 12'h000, 0, 1, 13'd0, 0, 13'd0);
        idle();

        // 100-pixel partial frame with a same-address read-during-write at 50.
        for (int i = 0; i < 100; i++)
            drive(0, i == 0, 1, pat2(i), 0, i == 50, 13'd50, 0, 13'd0);

        // Restart -> frame_short; lock mid-frame must not interrupt; locked start is skipped.
        for (int i = 0; i < NPX; i++)
            drive(0, i == 0 || i == 2000, 1, pat2(i), i >= 1500 && i <= 2500,
                  0, 13'd0, i == 4799, 13'd4799);
        idle();
        idle();

        // Reset in mid-capture abandons the frame.
        for (int i = 0; i < 2000; i++) drive(0, i == 0, 1, pat3(i), 0, 0, 13'd0, 0, 13'd0);
        drive(1, 0, 1, 12'h777, 0, 1, 13'd3, 1, 13'd9);
        chk_quiet("midrst");
        drive(0, 0, 1, 12'h555, 0, 0, 13'd0, 0, 13'd0);
        drive(0, 0, 0, 12'h000, 0, 1, 13'd1999, 0, 13'd0);
        drive(0, 0, 0, 12'h000, 0, 0, 13'd0, 1, 13'd2000);
        idle();
        idle();
        idle();

        chk("wr_q_left", 64'(wr_q.size()), 64'd0);
        chk("disp_q_left", 64'(rq[0].size()), 64'd0);
        chk("proc_q_left", 64'(rq[1].size()), 64'd0);
        for (int i = 0; i < 4; i++) chk({pname(i), "_q_left"}, 64'(pq[i].size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
